// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions N_BTN raw push-button / switch pins for use by downstream logic
// (LED modes, menu control). Each pin passes through a two-flop synchroniser,
// is normalised so that 1 means "pressed", and is then debounced by a
// per-button counter and four-state FSM. The result is a clean level plus
// one-cycle press, release and long-press event pulses.
//
// Parameters
//   N_BTN           number of independent buttons
//   ACTIVE_LOW      1: raw pin reads 0 when pressed; 0: raw pin reads 1
//   DEBOUNCE_CYCLES stable hwclk cycles needed to accept a level change (>= 2)
//   LONG_CYCLES     hwclk cycles a debounced press is held before btn_long (>= 2)
//
// Ports
//   hwclk          in   system clock, all logic on its rising edge
//   rst            in   synchronous, active-high reset
//   btn_raw        in   [N_BTN] asynchronous raw button pins
//   btn_state      out  [N_BTN] debounced level, 1 = pressed
//   btn_press      out  [N_BTN] one-cycle pulse on accepted press
//   btn_release    out  [N_BTN] one-cycle pulse on accepted release
//   btn_long       out  [N_BTN] one-cycle pulse when hold reaches LONG_CYCLES
//   btn_held_long  out  [N_BTN] high from the btn_long pulse until release
//
// All outputs come straight from flops; there is no combinational path from
// btn_raw to any output.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int N_BTN           = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 262144,
  parameter int LONG_CYCLES     = 8388608
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_held_long
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; the hold counter
  // must be able to sit at LONG_CYCLES once saturated.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  // Raw pin level that corresponds to a released button.
  localparam logic [N_BTN-1:0] RELEASED_LEVEL = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } db_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Both stages reset to the released level so that a
  // button held through reset must re-qualify from scratch.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;
  logic [N_BTN-1:0] synced;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      sync1_reg <= RELEASED_LEVEL;
      sync2_reg <= RELEASED_LEVEL;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Polarity normalisation after the second flop: XOR with the released
  // level turns "released" into 0 and "pressed" into 1 for either polarity.
  assign synced = sync2_reg ^ RELEASED_LEVEL;

  // ---------------------------------------------------------------------------
  // Per-button debounce FSM and long-press tracking. Bits are fully
  // independent, so any combination may pulse in the same cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn

    db_state_t         fsm_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              state_reg;
    logic              press_reg;
    logic              release_reg;
    logic              long_reg;
    logic              held_long_reg;

    logic              db_done;
    logic              releasing;

    // The counter has seen DEBOUNCE_CYCLES-1 differing samples already; one
    // more differing sample accepts the change.
    assign db_done = (db_cnt_reg == DB_LAST);

    // True on the edge that accepts a release; used to clear the long-press
    // level on the same edge as btn_release.
    assign releasing = (fsm_reg == ST_RELEASE_PEND) && !synced[gi] && db_done;

    // Debounce FSM. state_reg mirrors "PRESSED or RELEASE_PEND" but is kept
    // as its own flop so btn_state is a registered output.
    always_ff @(posedge hwclk) begin
      if (rst) begin
        fsm_reg     <= ST_RELEASED;
        db_cnt_reg  <= '0;
        state_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        case (fsm_reg)
          ST_RELEASED: begin
            if (synced[gi]) begin
              // First differing sample already counts toward the total.
              fsm_reg    <= ST_PRESS_PEND;
              db_cnt_reg <= db_cnt_reg + DB_ONE;
            end else begin
              db_cnt_reg <= '0;
            end
          end
          ST_PRESS_PEND: begin
            if (!synced[gi]) begin
              // Bounce back to released before qualifying: discard.
              fsm_reg    <= ST_RELEASED;
              db_cnt_reg <= '0;
            end else if (db_done) begin
              fsm_reg    <= ST_PRESSED;
              db_cnt_reg <= '0;
              state_reg  <= 1'b1;
              press_reg  <= 1'b1;
            end else begin
              db_cnt_reg <= db_cnt_reg + DB_ONE;
            end
          end
          ST_PRESSED: begin
            if (!synced[gi]) begin
              fsm_reg    <= ST_RELEASE_PEND;
              db_cnt_reg <= db_cnt_reg + DB_ONE;
            end else begin
              db_cnt_reg <= '0;
            end
          end
          ST_RELEASE_PEND: begin
            if (synced[gi]) begin
              // Bounce back to pressed: the hold counter is unaffected
              // because btn_state never dropped.
              fsm_reg    <= ST_PRESSED;
              db_cnt_reg <= '0;
            end else if (db_done) begin
              fsm_reg     <= ST_RELEASED;
              db_cnt_reg  <= '0;
              state_reg   <= 1'b0;
              release_reg <= 1'b1;
            end else begin
              db_cnt_reg <= db_cnt_reg + DB_ONE;
            end
          end
          default: begin
            fsm_reg    <= ST_RELEASED;
            db_cnt_reg <= '0;
            state_reg  <= 1'b0;
          end
        endcase
      end
    end

    // Hold counter and long-press outputs. The counter looks at the current
    // registered btn_state, so it is still 0 on the edge btn_state rises and
    // reaches LONG_CYCLES exactly LONG_CYCLES edges after the press pulse.
    always_ff @(posedge hwclk) begin
      if (rst) begin
        hold_cnt_reg  <= '0;
        long_reg      <= 1'b0;
        held_long_reg <= 1'b0;
      end else begin
        long_reg <= 1'b0;

        if (!state_reg) begin
          hold_cnt_reg <= '0;
        end else if (hold_cnt_reg != HOLD_MAX) begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_ONE;
        end

        // Saturation guarantees the LONG_CYCLES-1 -> LONG_CYCLES step happens
        // at most once per press, hence a single btn_long pulse. A release
        // accepted on that very edge takes priority.
        if (releasing || !state_reg) begin
          held_long_reg <= 1'b0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          long_reg      <= 1'b1;
          held_long_reg <= 1'b1;
        end
      end
    end

    assign btn_state[gi]     = state_reg;
    assign btn_press[gi]     = press_reg;
    assign btn_release[gi]   = release_reg;
    assign btn_long[gi]      = long_reg;
    assign btn_held_long[gi] = held_long_reg;

  end : g_btn

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with N_BTN=4, ACTIVE_LOW=1,
// DEBOUNCE_CYCLES=4, LONG_CYCLES=10. Inputs are driven 1 ns after a rising
// edge and outputs are sampled at the same point, so each step() shows the
// registered result of exactly one edge. All five output vectors are packed
// into one 20-bit word {state, press, release, long, held_long} per check.
// With DEBOUNCE_CYCLES=4 an accepted change appears on the 6th edge after the
// raw pin is driven; btn_long appears on the 10th edge after btn_press.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int N_BTN           = 4;
  localparam bit ACTIVE_LOW      = 1'b1;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LONG_CYCLES     = 10;

  logic             hwclk = 1'b0;
  logic             rst   = 1'b1;
  logic [N_BTN-1:0] btn_raw = 4'hF;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_held_long;

  int errors = 0;
  int checks = 0;

  always #5 hwclk = ~hwclk;

  button_debouncer #(
    .N_BTN          (N_BTN),
    .ACTIVE_LOW     (ACTIVE_LOW),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) dut (
    .hwclk        (hwclk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_state    (btn_state),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_long     (btn_long),
    .btn_held_long(btn_held_long)
  );

  function automatic logic [19:0] outs();
    return {btn_state, btn_press, btn_release, btn_long, btn_held_long};
  endfunction

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  // 1. Reset with all pins released, then idle.
  task automatic test_reset();
    rst = 1'b1;
    btn_raw = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    $display("test_reset: complete, checks so far %0d", checks);
  endtask

  // 2. Single press on bit 0, press pulse on the 6th edge, then release.
  task automatic test_single_press();
    logic [19:0] exp;
    btn_raw = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL press0_wait cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL press0_edge: got %h want %h", outs(), exp);
    end
    step();
    exp = {4'b0001, 16'h0};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL press0_after: got %h want %h", outs(), exp);
    end
    btn_raw = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL release0_wait cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL release0_edge: got %h want %h", outs(), exp);
    end
    step();
    checks++;
    if (outs() !== 20'h0) begin
      errors++;
      $display("FAIL release0_after: got %h want %h", outs(), 20'h0);
    end
    $display("test_single_press: complete, checks so far %0d", checks);
  endtask

  // 3. Two-cycle low glitches on bit 1 must be rejected; a following clean
  //    press must still take the full debounce time (counter was cleared).
  task automatic test_glitch();
    logic [19:0] exp;
    for (int i = 0; i < 14; i++) begin
      btn_raw = (i < 6 && ((i / 2) % 2) == 0) ? 4'b1101 : 4'hF;
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL glitch1 cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    btn_raw = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL glitch1_clean_wait cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL glitch1_clean_press: got %h want %h", outs(), exp);
    end
    btn_raw = 4'hF;
    exp = {4'b0010, 16'h0};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL glitch1_rel_wait cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL glitch1_release: got %h want %h", outs(), exp);
    end
    step();
    $display("test_glitch: complete, checks so far %0d", checks);
  endtask

  // 4. Long press on bit 2: btn_long 10 edges after btn_press, held_long
  //    until the release edge, exactly one long pulse.
  task automatic test_long_press();
    logic [19:0] exp;
    int long_count;
    long_count = 0;
    btn_raw = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL long2_wait cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL long2_press: got %h want %h", outs(), exp);
    end
    exp = {4'b0100, 16'h0};
    for (int i = 1; i < 10; i++) begin
      step();
      long_count += int'(btn_long[2]);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL long2_hold edge+%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    long_count += int'(btn_long[2]);
    exp = {4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL long2_pulse edge+10: got %h want %h", outs(), exp);
    end
    exp = {4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      step();
      long_count += int'(btn_long[2]);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL long2_held cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    btn_raw = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      long_count += int'(btn_long[2]);
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL long2_rel_wait cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL long2_release: got %h want %h", outs(), exp);
    end
    step();
    checks++;
    if (outs() !== 20'h0) begin
      errors++;
      $display("FAIL long2_after: got %h want %h", outs(), 20'h0);
    end
    checks++;
    if (long_count !== 1) begin
      errors++;
      $display("FAIL long2_count: got %0d want %0d", long_count, 1);
    end
    $display("test_long_press: complete, checks so far %0d", checks);
  endtask

  // 5. Short press (no long pulse), then bits 0 and 3 together.
  task automatic test_short_and_simultaneous();
    logic [19:0] exp;
    btn_raw = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL short0_wait cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL short0_press: got %h want %h", outs(), exp);
    end
    btn_raw = 4'hF;
    exp = {4'b0001, 16'h0};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL short0_rel_wait cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL short0_release: got %h want %h", outs(), exp);
    end
    // Covers the edge where a long pulse would have appeared had the hold
    // counter not been cleared by the release.
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL short0_no_long cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    btn_raw = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL simul_wait cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL simul_press: got %h want %h", outs(), exp);
    end
    btn_raw = 4'hF;
    exp = {4'b1001, 16'h0};
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL simul_rel_wait cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL simul_release: got %h want %h", outs(), exp);
    end
    step();
    $display("test_short_and_simultaneous: complete, checks so far %0d", checks);
  endtask

  // 6. Reset during a hold on bit 3: full re-qualification afterwards.
  task automatic test_reset_midhold();
    logic [19:0] exp;
    btn_raw = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL midrst_wait cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midrst_press: got %h want %h", outs(), exp);
    end
    exp = {4'b1000, 16'h0};
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL midrst_hold cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (outs() !== 20'h0) begin
      errors++;
      $display("FAIL midrst_in_reset: got %h want %h", outs(), 20'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== 20'h0) begin
        errors++;
        $display("FAIL midrst_requal cyc%0d: got %h want %h", i, outs(), 20'h0);
      end
    end
    step();
    exp = {4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midrst_repress: got %h want %h", outs(), exp);
    end
    exp = {4'b1000, 16'h0};
    for (int i = 1; i < 10; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL midrst_hold2 edge+%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midrst_long edge+10: got %h want %h", outs(), exp);
    end
    step();
    exp = {4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midrst_held: got %h want %h", outs(), exp);
    end
    btn_raw = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL midrst_rel_wait cyc%0d: got %h want %h", i, outs(), exp);
      end
    end
    step();
    exp = {4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL midrst_release: got %h want %h", outs(), exp);
    end
    $display("test_reset_midhold: complete, checks so far %0d", checks);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_long_press();
    test_short_and_simultaneous();
    test_reset_midhold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
